// File: rtl/count_evt_capture.sv
// count_evt_capture
// Watches an up/down counter's output, detects compare-match and wrap-around
// events, and queues each as a {type,value} record in a small FIFO that drains
// over a valid/ready port. A record dropped on a full FIFO sets a sticky flag.

module count_evt_capture #(
   parameter int unsigned       WIDTH   = 32,
   parameter int unsigned       DEPTH   = 4,
   parameter logic [WIDTH-1:0]  CMP_RST = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mode,
   input  logic                       load,
   input  logic [WIDTH-1:0]           count_in,
   input  logic                       cmp_wr,
   input  logic [WIDTH-1:0]           cmp_val,
   output logic                       ev_valid,
   input  logic                       ev_ready,
   output logic [1:0]                 ev_type,
   output logic [WIDTH-1:0]           ev_value,
   output logic [$clog2(DEPTH):0]     ev_count,
   output logic                       ovf,
   input  logic                       ovf_clr
);

   localparam int unsigned      AW       = $clog2(DEPTH);
   localparam int unsigned      CW       = AW + 1;
   localparam int unsigned      RW       = WIDTH + 2;
   localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ALL_ZERO = '0;

   // Sampling and compare state
   logic [WIDTH-1:0] prev_q,     prev_d;
   logic             prev_vld_q, prev_vld_d;
   logic             ld_q,       ld_d;
   logic [WIDTH-1:0] cmp_q,      cmp_d;

   // FIFO control state
   logic [AW-1:0]    wr_ptr_q,   wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q,   rd_ptr_d;
   logic [CW-1:0]    count_q,    count_d;
   logic             ovf_q,      ovf_d;

   // FIFO storage, one {type,value} record per entry
   logic [RW-1:0]    mem_q [DEPTH];
   logic [RW-1:0]    rec_d;
   logic [RW-1:0]    head;

   // Event detection and FIFO handshake terms
   logic             is_match;
   logic             is_wrap;
   logic             up_wrap;
   logic             down_wrap;
   logic             ev_push;
   logic             ev_pop;
   logic             fifo_full;
   logic             push_ok;
   logic             push_drop;

   // Detect match/wrap against the previous sample and the active compare value
   always_comb begin
      is_match  = (count_in == cmp_q) && (!prev_vld_q || (count_in != prev_q));
      up_wrap   = mode  && (prev_q == ALL_ONES) && (count_in == ALL_ZERO);
      down_wrap = !mode && (prev_q == ALL_ZERO) && (count_in == ALL_ONES);
      // A jump caused by a load (this cycle or last) is never a wrap
      is_wrap   = prev_vld_q && !ld_q && !load && (up_wrap || down_wrap);
      ev_push   = is_match || is_wrap;
      rec_d     = {is_wrap, is_match, count_in};
   end

   // Push/pop arbitration; a pop frees the slot for a same-cycle push when full
   always_comb begin
      fifo_full = (count_q == FULL_CNT);
      ev_pop    = (count_q != '0) && ev_ready;
      push_ok   = ev_push && (!fifo_full || ev_pop);
      push_drop = ev_push && fifo_full && !ev_pop;
   end

   // Next-state for sampling registers, compare register and FIFO bookkeeping
   always_comb begin
      prev_d     = count_in;
      prev_vld_d = 1'b1;
      ld_d       = load;
      cmp_d      = cmp_wr ? cmp_val : cmp_q;

      wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = ev_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

      count_d    = count_q;
      case ({push_ok, ev_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // A drop in the same cycle as a clear leaves the flag set
      ovf_d = ovf_q;
      if (push_drop) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   // Control registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q     <= '0;
         prev_vld_q <= 1'b0;
         ld_q       <= 1'b0;
         cmp_q      <= CMP_RST;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
      end else begin
         prev_q     <= prev_d;
         prev_vld_q <= prev_vld_d;
         ld_q       <= ld_d;
         cmp_q      <= cmp_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
      end
   end

   // Record storage; no reset needed since occupancy gates every read
   always_ff @(posedge clk) begin
      if (push_ok && !rst) begin
         mem_q[wr_ptr_q] <= rec_d;
      end
   end

   // Head of queue is presented directly so a record is visible the cycle after its push
   always_comb begin
      head     = mem_q[rd_ptr_q];
      ev_valid = (count_q != '0);
      ev_type  = head[RW-1:WIDTH];
      ev_value = head[WIDTH-1:0];
      ev_count = count_q;
      ovf      = ovf_q;
   end

endmodule

// File: tb/tb_count_evt_capture.sv
// tb_count_evt_capture
// Directed test of count_evt_capture: reset, match, wrap, load suppression,
// combined events, FIFO fill/overflow/drain ordering and simultaneous push+pop.

module tb_count_evt_capture;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 4;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    mode;
   logic                    load;
   logic [WIDTH-1:0]        count_in;
   logic                    cmp_wr;
   logic [WIDTH-1:0]        cmp_val;
   logic                    ev_valid;
   logic                    ev_ready;
   logic [1:0]              ev_type;
   logic [WIDTH-1:0]        ev_value;
   logic [$clog2(DEPTH):0]  ev_count;
   logic                    ovf;
   logic                    ovf_clr;

   int n_checks = 0;
   int n_errors = 0;

   count_evt_capture #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .CMP_RST ('0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .mode     (mode),
      .load     (load),
      .count_in (count_in),
      .cmp_wr   (cmp_wr),
      .cmp_val  (cmp_val),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .ev_type  (ev_type),
      .ev_value (ev_value),
      .ev_count (ev_count),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr)
   );

   always #5 clk = ~clk;

   // One comparison: count it, print one line, flag a mismatch
   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   // Advance one clock; outputs are sampled 1 ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [WIDTH-1:0] cnt);
      count_in = cnt;
      step();
   endtask

   logic [WIDTH-1:0] drain_exp [4];

   initial begin
      rst      = 1'b1;
      mode     = 1'b1;
      load     = 1'b0;
      count_in = 32'h5;
      cmp_wr   = 1'b0;
      cmp_val  = '0;
      ev_ready = 1'b0;
      ovf_clr  = 1'b0;
      step();
      step();
      check_eq("por_valid", 64'(ev_valid), 64'd0);
      check_eq("por_count", 64'(ev_count), 64'd0);
      check_eq("por_ovf",   64'(ovf),      64'd0);

      rst = 1'b0;
      drive(32'h5);
      check_eq("idle_valid", 64'(ev_valid), 64'd0);

      // Single match at 0x10 while counting up, consumer always ready
      cmp_wr  = 1'b1;
      cmp_val = 32'h10;
      drive(32'h0D);
      cmp_wr   = 1'b0;
      ev_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(32'h0E + 32'(i));
         check_eq($sformatf("m_valid_%0d", i), 64'(ev_valid), (i == 2) ? 64'd1 : 64'd0);
         if (i == 2) begin
            check_eq("m_type",  64'(ev_type),  64'd1);
            check_eq("m_value", 64'(ev_value), 64'h10);
         end
      end

      // Load 0xFFFFFFFE then count up through the wrap
      load = 1'b1;
      drive(32'h12);
      load = 1'b0;
      drive(32'hFFFF_FFFE);
      check_eq("w_pre1", 64'(ev_valid), 64'd0);
      drive(32'hFFFF_FFFF);
      check_eq("w_pre2", 64'(ev_valid), 64'd0);
      drive(32'h0);
      check_eq("w_valid", 64'(ev_valid), 64'd1);
      check_eq("w_type",  64'(ev_type),  64'd2);
      check_eq("w_value", 64'(ev_value), 64'h0);
      drive(32'h1);
      check_eq("w_post", 64'(ev_valid), 64'd0);

      // Jump from all-ones to zero right after a load strobe: no wrap
      drive(32'hFFFF_FFFF);
      load = 1'b1;
      drive(32'hFFFF_FFFF);
      load = 1'b0;
      drive(32'h0);
      check_eq("j_ldq", 64'(ev_valid), 64'd0);
      // Jump coinciding with the load strobe itself: no wrap
      drive(32'hFFFF_FFFF);
      load = 1'b1;
      drive(32'h0);
      check_eq("j_load", 64'(ev_valid), 64'd0);
      load = 1'b0;
      drive(32'h0);
      check_eq("j_after", 64'(ev_valid), 64'd0);

      // Down count through zero with compare at all-ones: combined record
      mode    = 1'b0;
      cmp_wr  = 1'b1;
      cmp_val = 32'hFFFF_FFFF;
      drive(32'h3);
      cmp_wr = 1'b0;
      drive(32'h2);
      drive(32'h1);
      drive(32'h0);
      check_eq("c_pre", 64'(ev_valid), 64'd0);
      drive(32'hFFFF_FFFF);
      check_eq("c_valid", 64'(ev_valid), 64'd1);
      check_eq("c_type",  64'(ev_type),  64'd3);
      check_eq("c_value", 64'(ev_value), 64'hFFFF_FFFF);
      drive(32'hFFFF_FFFE);
      check_eq("c_post", 64'(ev_valid), 64'd0);

      // Five matches with consumer stalled: fill, then overflow
      mode     = 1'b1;
      ev_ready = 1'b0;
      cmp_wr   = 1'b1;
      cmp_val  = 32'h40;
      drive(32'h3F);
      for (int i = 0; i < 5; i++) begin
         cmp_val = 32'h41 + 32'(i);
         drive(32'h40 + 32'(i));
         check_eq($sformatf("f_count_%0d", i), 64'(ev_count), (i < 4) ? 64'(i + 1) : 64'd4);
         check_eq($sformatf("f_ovf_%0d", i),   64'(ovf),      (i == 4) ? 64'd1 : 64'd0);
         check_eq($sformatf("f_head_%0d", i),  64'(ev_value), 64'h40);
      end
      // Drop coinciding with a clear: flag stays set
      cmp_val = 32'h46;
      ovf_clr = 1'b1;
      drive(32'h45);
      check_eq("o_setwins", 64'(ovf),      64'd1);
      check_eq("o_count",   64'(ev_count), 64'd4);
      cmp_wr = 1'b0;
      drive(32'h50);
      check_eq("o_clr", 64'(ovf), 64'd0);
      ovf_clr = 1'b0;
      check_eq("o_head", 64'(ev_value), 64'h40);

      // Full FIFO, push and pop in the same cycle
      ev_ready = 1'b1;
      drive(32'h46);
      check_eq("pp_count", 64'(ev_count), 64'd4);
      check_eq("pp_ovf",   64'(ovf),      64'd0);

      // Drain in order; 0x44 and 0x45 were dropped, 0x46 sits at the tail
      drain_exp[0] = 32'h41;
      drain_exp[1] = 32'h42;
      drain_exp[2] = 32'h43;
      drain_exp[3] = 32'h46;
      count_in = 32'h50;
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("d_valid_%0d", i), 64'(ev_valid), 64'd1);
         check_eq($sformatf("d_type_%0d", i),  64'(ev_type),  64'd1);
         check_eq($sformatf("d_value_%0d", i), 64'(ev_value), 64'(drain_exp[i]));
         step();
      end
      check_eq("d_empty_valid", 64'(ev_valid), 64'd0);
      check_eq("d_empty_count", 64'(ev_count), 64'd0);
      step();
      check_eq("rdy_empty_count", 64'(ev_count), 64'd0);
      check_eq("rdy_empty_valid", 64'(ev_valid), 64'd0);

      // Queue three records, then reset mid-run
      ev_ready = 1'b0;
      cmp_wr   = 1'b1;
      cmp_val  = 32'h60;
      drive(32'h5F);
      for (int i = 0; i < 3; i++) begin
         cmp_val = 32'h61 + 32'(i);
         drive(32'h60 + 32'(i));
      end
      cmp_wr = 1'b0;
      check_eq("r_queued", 64'(ev_count), 64'd3);
      rst = 1'b1;
      drive(32'h0);
      check_eq("r_valid1", 64'(ev_valid), 64'd0);
      drive(32'h0);
      check_eq("r_valid", 64'(ev_valid), 64'd0);
      check_eq("r_count", 64'(ev_count), 64'd0);
      check_eq("r_ovf",   64'(ovf),      64'd0);
      rst = 1'b0;
      drive(32'h0);
      check_eq("r_m_valid", 64'(ev_valid), 64'd1);
      check_eq("r_m_type",  64'(ev_type),  64'd1);
      check_eq("r_m_value", 64'(ev_value), 64'h0);
      check_eq("r_m_count", 64'(ev_count), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
